// File: rtl/adder_pkg.sv
// Shared definitions for the serial digit adder: FSM encoding and step-counter sizing.
package adder_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // A single-step operation still needs a one-bit counter.
  function automatic int unsigned step_width(int unsigned nstep);
    return (nstep > 1) ? $clog2(nstep) : 1;
  endfunction

endpackage

// File: rtl/digit_adder.sv
// Combinational DIGIT-bit ripple-carry adder built from gate primitives.
module digit_adder #(
  parameter int unsigned DIGIT = 2
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] s,
  output logic             cout,
  output logic             c_msb
);

  logic [DIGIT:0]   c;
  logic [DIGIT-1:0] p;
  logic [DIGIT-1:0] g;
  logic [DIGIT-1:0] t;

  assign c[0] = cin;

  for (genvar i = 0; i < DIGIT; i++) begin : g_fa
    xor u_xp (p[i], a[i], b[i]);
    xor u_xs (s[i], p[i], c[i]);
    and u_ag (g[i], a[i], b[i]);
    and u_at (t[i], p[i], c[i]);
    or  u_oc (c[i+1], g[i], t[i]);
  end

  assign cout  = c[DIGIT];
  assign c_msb = c[DIGIT-1];

endmodule

// File: rtl/serial_digit_adder.sv
// Multi-cycle adder/subtractor: DIGIT bits per clock through a carry flip-flop,
// with start/busy/done handshake and an accumulate mode that reuses the last sum.
module serial_digit_adder #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic             acc_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);
  import adder_pkg::*;

  localparam int unsigned NSTEP = WIDTH / DIGIT;
  localparam int unsigned SW    = step_width(NSTEP);

  logic [1:0]       state_q, state_d;
  logic [SW-1:0]    step_q;
  logic [WIDTH-1:0] opa_q, opb_q, res_q, res_next;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q, cout_q, ovf_q;
  logic             accept, last;
  logic [DIGIT-1:0] dsum;
  logic             dcout, dcmsb;

  assign accept = start && (state_q == IDLE || state_q == DONE);
  assign last   = (state_q == RUN) && (step_q == SW'(NSTEP - 1));

  digit_adder #(
    .DIGIT(DIGIT)
  ) u_digit (
    .a    (opa_q[DIGIT-1:0]),
    .b    (opb_q[DIGIT-1:0]),
    .cin  (carry_q),
    .s    (dsum),
    .cout (dcout),
    .c_msb(dcmsb)
  );

  // New digits enter at the top so the first (least significant) digit ends up at bit 0.
  assign res_next = (res_q >> DIGIT) | (WIDTH'(dsum) << (WIDTH - DIGIT));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last) state_d = DONE;
      DONE:    state_d = start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      step_q  <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        opa_q   <= acc_mode ? sum_q : a;
        opb_q   <= sub ? ~b : b;
        carry_q <= sub;
        step_q  <= '0;
      end else if (state_q == RUN) begin
        opa_q   <= opa_q >> DIGIT;
        opb_q   <= opb_q >> DIGIT;
        res_q   <= res_next;
        carry_q <= dcout;
        step_q  <= step_q + SW'(1);
        if (last) begin
          sum_q  <= res_next;
          cout_q <= dcout;
          ovf_q  <= dcmsb ^ dcout;
        end
      end
    end
  end

  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign sum       = sum_q;
  assign carry_out = cout_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_serial_digit_adder.sv
// Directed bench: 8-bit/2-bit main instance plus 4/1 and 4/4 instances on shared inputs.
module tb_serial_digit_adder;

  logic       clk = 1'b0;
  logic       reset, start, sub, acc_mode;
  logic [7:0] a, b, sum;
  logic       busy, done, carry_out, overflow;

  logic       start4, sub4;
  logic [3:0] a4, b4, sum_d1, sum_d4;
  logic       busy_d1, done_d1, cout_d1, ovf_d1;
  logic       busy_d4, done_d4, cout_d4, ovf_d4;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  serial_digit_adder #(.WIDTH(8), .DIGIT(2)) u_dut (
    .clk(clk), .reset(reset), .start(start), .sub(sub), .acc_mode(acc_mode),
    .a(a), .b(b), .busy(busy), .done(done), .sum(sum),
    .carry_out(carry_out), .overflow(overflow)
  );

  serial_digit_adder #(.WIDTH(4), .DIGIT(1)) u_w4d1 (
    .clk(clk), .reset(reset), .start(start4), .sub(sub4), .acc_mode(1'b0),
    .a(a4), .b(b4), .busy(busy_d1), .done(done_d1), .sum(sum_d1),
    .carry_out(cout_d1), .overflow(ovf_d1)
  );

  serial_digit_adder #(.WIDTH(4), .DIGIT(4)) u_w4d4 (
    .clk(clk), .reset(reset), .start(start4), .sub(sub4), .acc_mode(1'b0),
    .a(a4), .b(b4), .busy(busy_d4), .done(done_d4), .sum(sum_d4),
    .carry_out(cout_d4), .overflow(ovf_d4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge where done is high (the DONE cycle).
  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb, input logic ts,
                        input logic tacc, output int lat, output int busy_cnt);
    bit seen = 0;
    a = ta; b = tb; sub = ts; acc_mode = tacc; start = 1'b1;
    lat = 0; busy_cnt = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy) busy_cnt++;
      if (done) begin
        lat = i - 1;
        seen = 1;
        break;
      end
    end
    if (!seen) begin
      n_total++; n_bad++;
      $display("FAIL timeout: done not seen within 20 cycles");
    end
  endtask

  task automatic run4(input logic [3:0] ta, input logic [3:0] tb, input logic ts,
                      input logic [3:0] es, input logic ec, input logic ev);
    bit s1 = 0, s4 = 0;
    logic [3:0] r1 = '0, r4 = '0;
    logic c1 = 0, c4 = 0, v1 = 0, v4 = 0;
    a4 = ta; b4 = tb; sub4 = ts; start4 = 1'b1;
    for (int i = 0; i < 12 && !(s1 && s4); i++) begin
      @(negedge clk);
      start4 = 1'b0;
      if (done_d1 && !s1) begin s1 = 1; r1 = sum_d1; c1 = cout_d1; v1 = ovf_d1; end
      if (done_d4 && !s4) begin s4 = 1; r4 = sum_d4; c4 = cout_d4; v4 = ovf_d4; end
    end
    check("w4d1 done", 32'(s1), 32'd1);
    check("w4d4 done", 32'(s4), 32'd1);
    check("w4d1 sum", 32'(r1), 32'(es));
    check("w4d1 cout", 32'(c1), 32'(ec));
    check("w4d1 ovf", 32'(v1), 32'(ev));
    check("w4d4 sum", 32'(r4), 32'(es));
    check("w4d4 cout", 32'(c4), 32'(ec));
    check("w4d4 ovf", 32'(v4), 32'(ev));
  endtask

  initial begin
    int lat, bc;
    bit done_seen;
    reset = 1'b1; start = 0; sub = 0; acc_mode = 0; a = '0; b = '0;
    start4 = 0; sub4 = 0; a4 = '0; b4 = '0;
    repeat (3) @(negedge clk);
    check("rst busy", 32'(busy), 0);
    check("rst done", 32'(done), 0);
    check("rst sum", 32'(sum), 0);
    check("rst cout", 32'(carry_out), 0);
    check("rst ovf", 32'(overflow), 0);
    reset = 1'b0;
    @(negedge clk);

    // 1: plain add with signed overflow
    run_op(8'h5A, 8'h33, 1'b0, 1'b0, lat, bc);
    check("t1 latency", 32'(lat), 4);
    check("t1 busy cycles", 32'(bc), 4);
    check("t1 sum", 32'(sum), 32'h8D);
    check("t1 cout", 32'(carry_out), 0);
    check("t1 ovf", 32'(overflow), 1);

    // 4: accumulate, issued in the DONE cycle of test 1
    run_op(8'h00, 8'h73, 1'b0, 1'b1, lat, bc);
    check("t4 latency", 32'(lat), 4);
    check("t4 sum", 32'(sum), 32'h00);
    check("t4 cout", 32'(carry_out), 1);
    check("t4 ovf", 32'(overflow), 0);

    // 2: wrap-around add
    @(negedge clk);
    run_op(8'hFF, 8'h01, 1'b0, 1'b0, lat, bc);
    check("t2 busy cycles", 32'(bc), 4);
    check("t2 sum", 32'(sum), 32'h00);
    check("t2 cout", 32'(carry_out), 1);
    check("t2 ovf", 32'(overflow), 0);

    // 3: subtract with borrow
    @(negedge clk);
    run_op(8'h10, 8'h20, 1'b1, 1'b0, lat, bc);
    check("t3 sum", 32'(sum), 32'hF0);
    check("t3 cout", 32'(carry_out), 0);
    check("t3 ovf", 32'(overflow), 0);

    // 5a: start pulse during RUN is ignored; previous result stays visible
    @(negedge clk);
    a = 8'h12; b = 8'h34; sub = 0; acc_mode = 0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    a = 8'h77; b = 8'h11; sub = 1; start = 1'b1;
    check("t5 sum held", 32'(sum), 32'hF0);
    check("t5 busy mid", 32'(busy), 1);
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    check("t5 done", 32'(done), 1);
    check("t5 sum", 32'(sum), 32'h46);
    check("t5 cout", 32'(carry_out), 0);

    // 5b: reset at step 2 of the next op aborts it
    a = 8'h01; b = 8'h01; sub = 0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("t5 rst busy", 32'(busy), 0);
    check("t5 rst done", 32'(done), 0);
    check("t5 rst sum", 32'(sum), 0);
    check("t5 rst cout", 32'(carry_out), 0);
    done_seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done) done_seen = 1;
    end
    check("t5 no done", 32'(done_seen), 0);

    // 6: narrow instances, DIGIT=1 and DIGIT=WIDTH
    run4(4'h7, 4'h1, 1'b0, 4'h8, 1'b0, 1'b1);
    run4(4'hF, 4'h1, 1'b0, 4'h0, 1'b1, 1'b0);
    run4(4'h8, 4'h8, 1'b0, 4'h0, 1'b1, 1'b1);
    run4(4'h5, 4'h3, 1'b0, 4'h8, 1'b0, 1'b1);
    run4(4'h3, 4'h5, 1'b1, 4'hE, 1'b0, 1'b0);
    run4(4'h8, 4'h1, 1'b1, 4'h7, 1'b1, 1'b1);
    run4(4'h5, 4'h5, 1'b1, 4'h0, 1'b1, 1'b0);
    run4(4'h0, 4'h8, 1'b1, 4'h8, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
